// File: rtl/calculador_nota_seq.sv
// Sequential grade calculator: sums N_CANAIS channel readings one per cycle,
// then divides the sum by a constant with a restoring shift-subtract divider
// (one quotient bit per cycle, MSB first) and presents a saturated quotient,
// the remainder and the raw sum.
//
// Handshake: nota_valida is raised when a result is ready and stays high, with
// nota/soma/resto/saturado stable, until an enabled clock edge sees
// nota_aceita=1; that edge consumes the result and the block returns to IDLE.
// A new computation is accepted only in IDLE on an enabled edge with inicio=1.
module calculador_nota_seq #(
    parameter int N_CANAIS = 4,
    parameter int LARGURA  = 4,
    parameter int DIVISOR  = 3,
    localparam int S       = LARGURA + $clog2(N_CANAIS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        inicio,
    input  logic [N_CANAIS*LARGURA-1:0] canais,
    output logic                        ocupado,
    output logic                        nota_valida,
    input  logic                        nota_aceita,
    output logic [LARGURA-1:0]          nota,
    output logic [S-1:0]                soma,
    output logic [LARGURA-1:0]          resto,
    output logic                        saturado,
    output logic [1:0]                  estado
);

    localparam int IW = $clog2(N_CANAIS);
    localparam int CW = $clog2(S);
    localparam logic [IW-1:0]    IDX_LAST = IW'(N_CANAIS - 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(S - 1);
    localparam logic [LARGURA:0] DIV_EXT  = (LARGURA + 1)'(DIVISOR);

    // A zero or over-wide divisor cannot be represented by the datapath.
    if (DIVISOR < 1 || DIVISOR > (1 << LARGURA) - 1) begin : g_bad_divisor
        $error("calculador_nota_seq: DIVISOR out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SOMA   = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } estado_t;

    estado_t                        st, st_next;
    logic [N_CANAIS*LARGURA-1:0]    canais_reg;
    logic [IW-1:0]                  idx;
    logic [S-1:0]                   acc;
    logic [S-1:0]                   dq;       // dividend shifting out, quotient shifting in
    logic [LARGURA-1:0]             rem;
    logic [CW-1:0]                  cnt;

    logic [LARGURA-1:0]             canal_atual;
    logic [S-1:0]                   soma_parcial;
    logic [LARGURA:0]               trial;
    logic [LARGURA:0]               diff;
    logic                           trial_ge;
    logic [LARGURA-1:0]             rem_next;
    logic [S-1:0]                   dq_next;
    logic                           sat_next;

    assign estado      = st;
    assign ocupado     = (st != IDLE);
    assign nota_valida = (st == DONE);

    // Channel adder and one restoring-division step.
    always_comb begin
        canal_atual  = canais_reg[idx*LARGURA +: LARGURA];
        soma_parcial = acc + {{(S - LARGURA){1'b0}}, canal_atual};
        trial        = {rem, dq[S-1]};
        diff         = trial - DIV_EXT;
        trial_ge     = (trial >= DIV_EXT);
        rem_next     = trial_ge ? diff[LARGURA-1:0] : trial[LARGURA-1:0];
        dq_next      = {dq[S-2:0], trial_ge};
        sat_next     = |dq_next[S-1:LARGURA];
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            st <= IDLE;
        end else begin
            st <= st_next;
        end
    end

    // Next-state logic; a disabled cycle freezes the state.
    always_comb begin
        st_next = st;
        if (enable) begin
            case (st)
                IDLE:    if (inicio)          st_next = SOMA;
                SOMA:    if (idx == IDX_LAST) st_next = DIVIDE;
                DIVIDE:  if (cnt == CNT_LAST) st_next = DONE;
                DONE:    if (nota_aceita)     st_next = IDLE;
                default:                      st_next = IDLE;
            endcase
        end
    end

    // Datapath: capture, accumulate, divide, publish results.
    always_ff @(posedge clock) begin
        if (reset) begin
            canais_reg <= '0;
            idx        <= '0;
            acc        <= '0;
            dq         <= '0;
            rem        <= '0;
            cnt        <= '0;
            nota       <= '0;
            soma       <= '0;
            resto      <= '0;
            saturado   <= 1'b0;
        end else if (enable) begin
            case (st)
                IDLE: begin
                    if (inicio) begin
                        canais_reg <= canais;
                        acc        <= '0;
                        idx        <= '0;
                    end
                end
                SOMA: begin
                    acc <= soma_parcial;
                    idx <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        dq  <= soma_parcial;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                DIVIDE: begin
                    dq  <= dq_next;
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        soma     <= acc;
                        resto    <= rem_next;
                        saturado <= sat_next;
                        nota     <= sat_next ? {LARGURA{1'b1}} : dq_next[LARGURA-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculador_nota_seq.sv
// Bench for calculador_nota_seq: a default-parameter instance checked every
// cycle against a transaction-level model, and an 8x6-bit / divisor 5
// instance checked per transaction against a reference function.
module tb_calculador_nota_seq;

    localparam int N  = 4, L  = 4, D  = 3, S  = 6;
    localparam int N2 = 8, L2 = 6, D2 = 5, S2 = 9;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset, enable, inicio, nota_aceita;
    logic [N*L-1:0]   canais;
    logic             ocupado, nota_valida, saturado;
    logic [L-1:0]     nota, resto;
    logic [S-1:0]     soma;
    logic [1:0]       estado;

    logic             reset2, enable2, inicio2, nota_aceita2;
    logic [N2*L2-1:0] canais2;
    logic             ocupado2, nota_valida2, saturado2;
    logic [L2-1:0]    nota2, resto2;
    logic [S2-1:0]    soma2;
    logic [1:0]       estado2;

    calculador_nota_seq dut (
        .clock(clock), .reset(reset), .enable(enable), .inicio(inicio),
        .canais(canais), .ocupado(ocupado), .nota_valida(nota_valida),
        .nota_aceita(nota_aceita), .nota(nota), .soma(soma), .resto(resto),
        .saturado(saturado), .estado(estado)
    );

    calculador_nota_seq #(.N_CANAIS(N2), .LARGURA(L2), .DIVISOR(D2)) dut2 (
        .clock(clock), .reset(reset2), .enable(enable2), .inicio(inicio2),
        .canais(canais2), .ocupado(ocupado2), .nota_valida(nota_valida2),
        .nota_aceita(nota_aceita2), .nota(nota2), .soma(soma2), .resto(resto2),
        .saturado(saturado2), .estado(estado2)
    );

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: sum of channels, quotient saturated to l bits, remainder.
    function automatic void ref_model(input logic [63:0] c, input int n, input int l, input int d,
                                      output int s, output int q, output int r, output int sat);
        int qq;
        s = 0;
        for (int i = 0; i < n; i++) s += int'((c >> (i * l)) & 64'((1 << l) - 1));
        qq  = s / d;
        r   = s % d;
        sat = (qq > (1 << l) - 1) ? 1 : 0;
        q   = sat ? (1 << l) - 1 : qq;
    endfunction

    // ---------------- model of the default instance ----------------
    // phase 0: idle, 1: computing (m_left edges to go), 2: result held.
    int m_phase = 0, m_left = 0;
    int m_nota = 0, m_soma = 0, m_resto = 0, m_sat = 0;
    int p_nota, p_soma, p_resto, p_sat;

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0; m_left = 0;
            m_nota = 0; m_soma = 0; m_resto = 0; m_sat = 0;
        end else if (enable) begin
            case (m_phase)
                0: if (inicio) begin
                    ref_model(64'(canais), N, L, D, p_soma, p_nota, p_resto, p_sat);
                    m_left  = N + S;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_soma = p_soma; m_nota = p_nota; m_resto = p_resto; m_sat = p_sat;
                        m_phase = 2;
                    end
                end
                default: if (nota_aceita) m_phase = 0;
            endcase
        end
    end

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("cyc_ocupado",     ocupado,     32'(m_phase != 0));
            chk("cyc_nota_valida", nota_valida, 32'(m_phase == 2));
            chk("cyc_nota",        nota,        m_nota);
            chk("cyc_soma",        soma,        m_soma);
            chk("cyc_resto",       resto,       m_resto);
            chk("cyc_saturado",    saturado,    m_sat);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start1(input logic [N*L-1:0] c);
        canais = c;
        inicio = 1'b1;
        @(negedge clock);
        inicio = 1'b0;
    endtask

    task automatic wait_valid1(input int first, input int maxc, output int lat);
        lat = first;
        while (!nota_valida && lat < maxc) begin
            @(negedge clock);
            lat++;
        end
        chk("valid_timeout", nota_valida, 1);
    endtask

    task automatic expect1(input string tag, input int s, input int q, input int r, input int sat);
        chk({tag, "_soma"}, soma, s);
        chk({tag, "_nota"}, nota, q);
        chk({tag, "_resto"}, resto, r);
        chk({tag, "_sat"}, saturado, sat);
    endtask

    task automatic run2(input logic [N2*L2-1:0] c, input string tag);
        int s, q, r, sat, lat;
        ref_model(64'(c), N2, L2, D2, s, q, r, sat);
        canais2 = c;
        inicio2 = 1'b1;
        @(negedge clock);
        inicio2 = 1'b0;
        canais2 = 48'({$urandom, $urandom});
        lat = 0;
        while (!nota_valida2 && lat < 80) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, "_lat"}, lat, N2 + S2);
        chk({tag, "_soma"}, soma2, s);
        chk({tag, "_nota"}, nota2, q);
        chk({tag, "_resto"}, resto2, r);
        chk({tag, "_sat"}, saturado2, sat);
        @(negedge clock);
        chk({tag, "_idle"}, ocupado2, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, cyc;
        logic [N2*L2-1:0] v;

        reset = 1'b1; enable = 1'b1; inicio = 1'b0; nota_aceita = 1'b1; canais = '0;
        reset2 = 1'b1; enable2 = 1'b1; inicio2 = 1'b0; nota_aceita2 = 1'b1; canais2 = '0;
        repeat (2) @(negedge clock);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_valida", nota_valida, 0);
        chk("rst_estado", estado, 0);
        expect1("rst", 0, 0, 0, 0);
        reset = 1'b0; reset2 = 1'b0;
        cmp_on = 1'b1;

        // Basic: {4,3,2,1} -> 10 / 3
        start1(16'h4321);
        wait_valid1(0, 40, lat);
        chk("basic_lat", lat, 10);
        expect1("basic", 10, 3, 1, 0);
        @(negedge clock);
        chk("basic_back_idle", ocupado, 0);
        chk("basic_valid_clr", nota_valida, 0);
        chk("basic_held_soma", soma, 10);

        // All ones: 60 / 3 = 20 saturates
        start1(16'hFFFF);
        wait_valid1(0, 40, lat);
        chk("max_lat", lat, 10);
        expect1("max", 60, 15, 0, 1);
        @(negedge clock);

        // All zeros
        start1(16'h0000);
        wait_valid1(0, 40, lat);
        chk("zero_lat", lat, 10);
        expect1("zero", 0, 0, 0, 0);
        @(negedge clock);

        // Back-pressure: result held, inicio and canais ignored
        nota_aceita = 1'b0;
        start1(16'h4321);
        wait_valid1(0, 40, lat);
        for (int k = 0; k < 5; k++) begin
            canais = 16'($urandom);
            inicio = (k % 2 == 0);
            @(negedge clock);
        end
        inicio = 1'b0;
        chk("hold_valid", nota_valida, 1);
        expect1("hold", 10, 3, 1, 0);
        nota_aceita = 1'b1;
        inicio = 1'b1;
        canais = 16'hFFFF;
        @(negedge clock);
        inicio = 1'b0;
        chk("hold_consumed", nota_valida, 0);
        chk("hold_inicio_ign", ocupado, 0);
        @(negedge clock);
        chk("hold_still_idle", ocupado, 0);

        // Enable low for 3 cycles inside DIVIDE
        start1(16'h4321);
        repeat (6) @(negedge clock);
        enable = 1'b0;
        repeat (3) @(negedge clock);
        enable = 1'b1;
        wait_valid1(9, 40, lat);
        chk("stall_lat", lat, 13);
        expect1("stall", 10, 3, 1, 0);
        @(negedge clock);

        // Reset on the 3rd DIVIDE edge, then restart on the first free edge
        start1(16'h4321);
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_ocupado", ocupado, 0);
        chk("abort_valida", nota_valida, 0);
        expect1("abort", 0, 0, 0, 0);
        start1(16'h2A7C);
        wait_valid1(0, 40, lat);
        chk("restart_lat", lat, 10);
        expect1("restart", 31, 10, 1, 0);
        @(negedge clock);

        // Reset wins over enable=0 while a result is held
        nota_aceita = 1'b0;
        start1(16'hFFFF);
        wait_valid1(0, 40, lat);
        enable = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b1;
        nota_aceita = 1'b1;
        chk("rst_dis_valida", nota_valida, 0);
        chk("rst_dis_soma", soma, 0);

        // Random traffic with random enable / accept / inicio
        for (int t = 0; t < 30; t++) begin
            enable = 1'b1;
            start1(16'($urandom));
            cyc = 0;
            while (ocupado && cyc < 300) begin
                enable      = ($urandom_range(0, 3) != 0);
                nota_aceita = 1'($urandom_range(0, 1));
                inicio      = 1'($urandom_range(0, 1));
                canais      = 16'($urandom);
                @(negedge clock);
                cyc++;
            end
            chk("rand_drain", ocupado, 0);
            inicio = 1'b0;
            enable = 1'b1;
            nota_aceita = 1'b1;
        end

        // Second configuration: 8 channels x 6 bits, divisor 5
        run2({8{6'd63}}, "w_max");
        expect1("w_max_dummy_guard", soma, nota, resto, saturado);
        chk("w_max_soma_lit", soma2, 504);
        chk("w_max_nota_lit", nota2, 63);
        chk("w_max_resto_lit", resto2, 4);
        chk("w_max_sat_lit", saturado2, 1);
        for (int i = 0; i < N2; i++) v[i*L2 +: L2] = 6'(i + 1);
        run2(v, "w_seq");
        chk("w_seq_nota_lit", nota2, 7);
        chk("w_seq_resto_lit", resto2, 1);

        canais2 = 48'({$urandom, $urandom});
        inicio2 = 1'b1;
        @(negedge clock);
        inicio2 = 1'b0;
        repeat (10) @(negedge clock);
        reset2 = 1'b1;
        @(negedge clock);
        reset2 = 1'b0;
        chk("w_abort_ocupado", ocupado2, 0);
        chk("w_abort_valida", nota_valida2, 0);
        chk("w_abort_soma", soma2, 0);
        chk("w_abort_nota", nota2, 0);
        chk("w_abort_resto", resto2, 0);
        chk("w_abort_sat", saturado2, 0);
        for (int t = 0; t < 8; t++) run2(48'({$urandom, $urandom}), "w_rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calculador_nota_seq.md
CALCULADOR_NOTA_SEQ -- requirements
Module: calculador_nota_seq

Interface
REQ-001 Parameter N_CANAIS, default 4: number of sensor channels averaged; legal range 2..16.
REQ-002 Parameter LARGURA, default 4: width of each channel reading and of nota; legal range 2..8.
REQ-003 Parameter DIVISOR, default 3: constant divisor applied to the channel sum; legal range 1..(2^LARGURA - 1); DIVISOR = 0 is a parameter error.
REQ-004 Derived width S = LARGURA + clog2(N_CANAIS), the sum width.
REQ-005 clock  in  1  sole clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  when 0, all registers hold their value; reset still applies.
REQ-008 inicio  in  1  request to start one computation.
REQ-009 canais  in  N_CANAIS*LARGURA  packed readings; channel i occupies bits [i*LARGURA+LARGURA-1 : i*LARGURA].
REQ-010 ocupado  out  1  high whenever the FSM is not in IDLE.
REQ-011 nota_valida  out  1  result valid; held until accepted.
REQ-012 nota_aceita  in  1  consumer accepts the result.
REQ-013 nota  out  LARGURA  saturated quotient sum/DIVISOR.
REQ-014 soma  out  S  registered channel sum of the current result.
REQ-015 resto  out  LARGURA  remainder sum mod DIVISOR.
REQ-016 saturado  out  1  high when the true quotient exceeds 2^LARGURA - 1.

Function
REQ-017 The FSM SHALL have states IDLE, SOMA, DIVIDE and DONE.
REQ-018 In IDLE with enable=1 and inicio=1, the block SHALL register canais, clear the accumulator and channel index, and go to SOMA; inicio in any other state SHALL be ignored.
REQ-019 In SOMA, each enabled edge SHALL add channel[index] to the S-bit accumulator and increment the index; after N_CANAIS adds the FSM SHALL go to DIVIDE.
REQ-020 The accumulator SHALL NOT overflow: S bits hold N_CANAIS*(2^LARGURA-1) exactly.
REQ-021 DIVIDE SHALL be a restoring shift-subtract divider producing one quotient bit per enabled edge, MSB first, for exactly S edges; no divide operator SHALL be used.
REQ-022 After the S-th divide edge, the FSM SHALL go to DONE and, on that same edge, update soma, resto, nota, saturado and set nota_valida=1.
REQ-023 nota SHALL equal the quotient when the quotient is at most 2^LARGURA-1, otherwise all ones with saturado=1.
REQ-024 Latency from the accepting edge to nota_valida rising SHALL be N_CANAIS+S enabled edges (10 with defaults).
REQ-025 In DONE, outputs SHALL stay stable while nota_aceita=0; an enabled edge with nota_aceita=1 SHALL clear nota_valida and return to IDLE; inicio on that edge SHALL be ignored.
REQ-026 nota, soma, resto and saturado SHALL hold their last value in IDLE until the next result overwrites them.
REQ-027 Changes on canais after the accepting edge SHALL NOT affect the result in progress.
REQ-028 With enable=0 in any state, the state, index, accumulator, divider and outputs SHALL hold; latency extends by the number of disabled cycles.

Reset
REQ-029 On a reset edge, regardless of enable or state, the FSM SHALL go to IDLE and ocupado, nota_valida, nota, soma, resto and saturado SHALL be 0.
REQ-030 A reset edge during SOMA, DIVIDE or DONE SHALL abandon the computation with no result delivered; inicio on the first edge after reset is released SHALL be accepted normally.

Verification
REQ-031 Defaults, canais={4,3,2,1}, inicio pulse, nota_aceita=1 -> after 10 edges nota_valida=1, soma=10, nota=3, resto=1, saturado=0; back in IDLE one edge later.
REQ-032 Defaults, all channels 15 -> soma=60, nota=15, resto=0, saturado=1.
REQ-033 Defaults, all channels 0 -> soma=0, nota=0, resto=0, saturado=0, latency 10.
REQ-034 nota_aceita=0 for 5 cycles after nota_valida, with canais changing and inicio pulsed -> outputs stable, no new computation; result consumed on the first edge with nota_aceita=1.
REQ-035 enable=0 for 3 cycles in the middle of DIVIDE -> same result as REQ-031, nota_valida after 13 edges.
REQ-036 reset asserted on the 3rd DIVIDE edge -> next edge all outputs 0, ocupado=0; new inicio completes correctly; repeat with N_CANAIS=8, LARGURA=6, DIVISOR=5 and random inputs compared against a reference model.
